program_loader: RTL

Serial program loader that writes the instruction memory, the other end of the CPU's instruction-fetch port. It accepts a framed byte stream (from a UART receiver or a debug host) over a valid/ready handshake, assembles 10-bit instructions from byte pairs, and writes them into consecutive instruction-memory addresses. It also validates a checksum and holds the CPU in reset while a load is in progress. It sits beside `InstructionMemory`: the CPU owns the read port and this block owns the write port.

---
 rtl/cpu_pkg.sv | 10 +
 rtl/program_loader_if.sv | 21 ++
 rtl/program_loader_instr_assembler.sv | 37 +++
 rtl/program_loader.sv | 97 +++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, frame header and loader FSM encoding
// Used by program_loader, InstructionMemory and PointCounter.
package cpu_pkg;
    localparam logic [7:0] HEADER = 8'hA5;
    localparam int INSTR_W = 10;
    localparam int IADDR_W = 8;
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_LO, S_HI, S_CSUM, S_DONE, S_ERR
    } state_t;
endpackage

// File: rtl/program_loader_if.sv
// program_loader_if: byte stream in and instruction-memory write port out
// rx_data/rx_valid/rx_ready: byte handshake from the host.
// imem_we/imem_addr/imem_wdata: write port into InstructionMemory.
// master: host side; slave: loader side.
interface program_loader_if;
    import cpu_pkg::*;
    logic [7:0] rx_data;
    logic rx_valid;
    logic rx_ready;
    logic imem_we;
    logic [IADDR_W-1:0] imem_addr;
    logic [INSTR_W-1:0] imem_wdata;
    modport master (
        output rx_data, rx_valid,
        input rx_ready, imem_we, imem_addr, imem_wdata
    );
    modport slave (
        input rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/program_loader_instr_assembler.sv
// instr_assembler: pairs LO/HI bytes into a word and writes it to consecutive addresses
// clk/reset: clock and sync active-high reset.
// clear: restart addressing at 0; lo_we/lo_byte: latch low byte;
// hi_we/hi_bits: form word and issue a write next cycle.
// imem_we/imem_addr/imem_wdata: registered write port.
module instr_assembler
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               lo_we,
    input  logic [7:0]         lo_byte,
    input  logic               hi_we,
    input  logic [1:0]         hi_bits,
    output logic               imem_we,
    output logic [IADDR_W-1:0] imem_addr,
    output logic [INSTR_W-1:0] imem_wdata
);
    logic [7:0] lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            lo         <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= hi_we;
            if (lo_we) lo <= lo_byte;
            if (hi_we) imem_wdata <= {hi_bits, lo};
            // address holds through the write strobe, then advances (wrapping 255->0)
            if (clear) imem_addr <= '0;
            else if (imem_we) imem_addr <= imem_addr + 1'b1;
        end
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: framed serial loader that writes instruction memory and holds the CPU
// clk/reset: clock and sync active-high reset.
// load_en: enables loading; dropping it mid-frame aborts to ERR.
// bus: byte handshake in, instruction-memory write port out.
// cpu_hold: keep CPU in reset; busy: frame in progress;
// done: one-cycle success pulse; error: sticky until reset or next header.
module program_loader
    import cpu_pkg::*;
#(
    parameter logic [7:0] HEADER_BYTE = HEADER
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     load_en,
    program_loader_if.slave bus,
    output logic     cpu_hold,
    output logic     busy,
    output logic     done,
    output logic     error
);
    state_t state, next;
    logic [7:0] sum, len, idx;
    logic acc, hdr, len_we, lo_we, hi_we, last;

    assign acc  = bus.rx_valid && bus.rx_ready;
    // LEN of 0 means 256, which the 8-bit wrap of len-1 handles for free
    assign last = idx == len - 8'd1;
    assign busy = state != S_IDLE && state != S_ERR;
    assign done = state == S_DONE;

    instr_assembler u_asm (
        .clk,
        .reset,
        .clear     (hdr),
        .lo_we,
        .lo_byte   (bus.rx_data),
        .hi_we,
        .hi_bits   (bus.rx_data[1:0]),
        .imem_we   (bus.imem_we),
        .imem_addr (bus.imem_addr),
        .imem_wdata(bus.imem_wdata)
    );

    always_comb begin
        next   = state;
        hdr    = 1'b0;
        len_we = 1'b0;
        lo_we  = 1'b0;
        hi_we  = 1'b0;
        if (state == S_IDLE || state == S_ERR) begin
            hdr  = acc && bus.rx_data == HEADER_BYTE;
            next = hdr ? S_LEN : state;
        end else if (state == S_DONE) begin
            next = S_IDLE;
        end else if (!load_en) begin
            // abort wins over any byte offered in the same cycle
            next = S_ERR;
        end else if (acc) begin
            case (state)
                S_LEN: begin
                    len_we = 1'b1;
                    next   = S_LO;
                end
                S_LO: begin
                    lo_we = 1'b1;
                    next  = S_HI;
                end
                S_HI: begin
                    hi_we = ~|bus.rx_data[7:2];
                    next  = !hi_we ? S_ERR : last ? S_CSUM : S_LO;
                end
                S_CSUM: next = bus.rx_data == sum ? S_DONE : S_ERR;
                default: next = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            bus.rx_ready <= 1'b0;
            sum         <= '0;
            len         <= '0;
            idx         <= '0;
            cpu_hold    <= 1'b0;
            error       <= 1'b0;
        end else begin
            state        <= next;
            bus.rx_ready <= load_en && next != S_DONE;
            sum          <= hdr ? 8'd0 : (lo_we || hi_we) ? sum + bus.rx_data : sum;
            len          <= len_we ? bus.rx_data : len;
            idx          <= hdr ? 8'd0 : hi_we ? idx + 8'd1 : idx;
            cpu_hold     <= hdr ? 1'b1 : state == S_DONE ? 1'b0 : cpu_hold;
            error        <= hdr ? 1'b0 : next == S_ERR ? 1'b1 : error;
        end
    end
endmodule
